// File: rtl/fpp_prog_sequencer.sv
// Programmable opcode sequencer for the FPP_16b core: runs a loaded instruction list,
// holding each opcode for its function's latency, with bus drive, result capture and abort.
module fpp_prog_sequencer #(
  parameter int DATA_W    = 16,
  parameter int OPC_W     = 8,
  parameter int ADDR_W    = 6,
  parameter int CYC_W     = 5,
  parameter int CYC_SHORT = 6,
  parameter int CYC_MUL   = 8,
  parameter int CYC_ADD   = 9,
  parameter int CYC_DIV   = 12,
  parameter logic [OPC_W-1:0] IDLE_OPC = OPC_W'(8'h10)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [ADDR_W:0]           prog_len,
  input  logic                      prog_we,
  input  logic [ADDR_W-1:0]         prog_addr,
  input  logic [OPC_W+DATA_W:0]     prog_wdata,
  output logic [OPC_W-1:0]          opcode,
  output logic [DATA_W-1:0]         bus_out,
  output logic                      bus_oe,
  input  logic [DATA_W-1:0]         bus_in,
  output logic [DATA_W-1:0]         result,
  output logic                      result_valid,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_W-1:0]         pc
);

  localparam int PROG_DEPTH = 2 ** ADDR_W;
  localparam int WORD_W     = 1 + OPC_W + DATA_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(PROG_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, FINISH} state_t;

  state_t              state;
  logic [WORD_W-1:0]   mem [PROG_DEPTH];
  logic [WORD_W-1:0]   rd_word;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W:0]     len;
  logic [CYC_W-1:0]    cnt;
  logic                launch;
  logic                cur_cap;

  logic                nxt_cap;
  logic [OPC_W-1:0]    nxt_opc;
  logic [DATA_W-1:0]   nxt_imm;
  logic                run_req;
  logic                last_cycle;
  logic                more;
  logic                do_issue;
  logic [ADDR_W-1:0]   new_idx;

  function automatic logic [CYC_W-1:0] hold_last(input logic [OPC_W-1:0] opc);
    case (opc[OPC_W-1 -: 4])
      4'b0010, 4'b1000: return CYC_W'(CYC_ADD - 1);
      4'b0110:          return CYC_W'(CYC_MUL - 1);
      4'b0101:          return CYC_W'(CYC_DIV - 1);
      default:          return CYC_W'(CYC_SHORT - 1);
    endcase
  endfunction

  assign {nxt_cap, nxt_opc, nxt_imm} = rd_word;
  assign run_req    = start && (prog_len != '0);
  assign last_cycle = (state == EXEC) && !launch && (cnt == '0);
  assign more       = ({1'b0, pc} + (ADDR_W + 1)'(1)) < len;
  assign do_issue   = (state == EXEC) && (launch || (last_cycle && more));
  assign new_idx    = launch ? '0 : pc + ADDR_W'(1);

  // rd_word always holds the word at rd_addr, so the next instruction is ready before the current one ends.
  always_ff @(posedge clk) begin
    if (prog_we && state == IDLE && !run_req)
      mem[prog_addr] <= prog_wdata;
    rd_word <= mem[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      opcode       <= IDLE_OPC;
      bus_out      <= '0;
      bus_oe       <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pc           <= '0;
      rd_addr      <= '0;
      len          <= '0;
      cnt          <= '0;
      launch       <= 1'b0;
      cur_cap      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      done         <= 1'b0;
      if (abort && state != IDLE) begin
        state  <= IDLE;
        opcode <= IDLE_OPC;
        bus_oe <= 1'b0;
        busy   <= 1'b0;
        launch <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (prog_len == '0) begin
                done <= 1'b1;
              end else begin
                state   <= FETCH;
                busy    <= 1'b1;
                pc      <= '0;
                rd_addr <= '0;
                len     <= (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
              end
            end
          end
          FETCH: begin
            state  <= EXEC;
            launch <= 1'b1;
          end
          EXEC: begin
            if (last_cycle && cur_cap) begin
              result       <= bus_in;
              result_valid <= 1'b1;
            end
            if (do_issue) begin
              opcode  <= nxt_opc;
              cur_cap <= nxt_cap;
              cnt     <= hold_last(nxt_opc);
              launch  <= 1'b0;
              pc      <= new_idx;
              rd_addr <= new_idx + ADDR_W'(1);
              // Only LOAD (function 0000) drives the shared bus; bus_out keeps its last value otherwise.
              if (nxt_opc[OPC_W-1 -: 4] == 4'b0000) begin
                bus_oe  <= 1'b1;
                bus_out <= nxt_imm;
              end else begin
                bus_oe <= 1'b0;
              end
            end else if (last_cycle) begin
              state  <= FINISH;
              opcode <= IDLE_OPC;
              bus_oe <= 1'b0;
              done   <= 1'b1;
            end else begin
              cnt <= cnt - CYC_W'(1);
            end
          end
          FINISH: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fpp_prog_sequencer.sv
// Directed bench for fpp_prog_sequencer: a table of single-instruction programs plus
// hand-written sequences for back-to-back issue, abort, write protection, depth and reset.
module tb_fpp_prog_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [6:0]  prog_len;
  logic        prog_we;
  logic [5:0]  prog_addr;
  logic [24:0] prog_wdata;
  logic [7:0]  opcode;
  logic [15:0] bus_out;
  logic        bus_oe;
  logic [15:0] bus_in;
  logic [15:0] result;
  logic        result_valid;
  logic        busy;
  logic        done;
  logic [5:0]  pc;

  logic [15:0] drive;
  logic [15:0] exp_result;
  int          n_checks = 0;
  int          n_pass   = 0;

  typedef struct {
    string       name;
    logic        cap;
    logic [7:0]  opc;
    logic [15:0] imm;
    logic [15:0] drv;
    int          hold;
    logic        oe;
  } vec_t;

  vec_t vecs[11];

  fpp_prog_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .prog_len(prog_len),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .opcode(opcode), .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in),
    .result(result), .result_valid(result_valid), .busy(busy), .done(done), .pc(pc)
  );

  always #5 clk = ~clk;

  // The shared bus as seen at the top level: the controller's value when it drives, otherwise the core's.
  assign bus_in = bus_oe ? bus_out : drive;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [5:0] a, input logic c, input logic [7:0] o, input logic [15:0] i);
    prog_we = 1'b1; prog_addr = a; prog_wdata = {c, o, i};
    step();
    prog_we = 1'b0;
  endtask

  task automatic pulse_start(input logic [6:0] len);
    prog_len = len; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic measure_hold(input logic [7:0] o, input logic oe_exp, input logic [15:0] imm,
                              output int n, output logic ok);
    n = 0; ok = 1'b1;
    while (opcode === o && n < 40) begin
      if (bus_oe !== oe_exp) ok = 1'b0;
      if (oe_exp && bus_out !== imm) ok = 1'b0;
      step();
      n++;
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    int   n;
    logic ok;
    write_word(6'd0, v.cap, v.opc, v.imm);
    drive = v.drv;
    pulse_start(7'd1);
    check_output({v.name, " busy"}, busy, 1);
    step(); step();
    measure_hold(v.opc, v.oe, v.imm, n, ok);
    check_output({v.name, " hold"}, n, v.hold);
    check_output({v.name, " bus"}, ok, 1);
    check_output({v.name, " done"}, done, 1);
    check_output({v.name, " idle opcode"}, opcode, 8'h10);
    if (v.cap) exp_result = v.oe ? v.imm : v.drv;
    check_output({v.name, " result_valid"}, result_valid, v.cap);
    check_output({v.name, " result"}, result, exp_result);
    step();
    check_output({v.name, " busy end"}, busy, 0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          n;
    logic        ok;
    logic        saw_done;
    logic        saw_rv;
    logic [7:0]  bb_opc [3];
    int          bb_hold [3];

    vecs[0]  = '{"load",      1'b0, 8'h00, 16'h3A00, 16'h0000, 6,  1'b1};
    vecs[1]  = '{"load cap",  1'b1, 8'h00, 16'h4242, 16'h1111, 6,  1'b1};
    vecs[2]  = '{"mul",       1'b0, 8'h61, 16'h0000, 16'h0000, 8,  1'b0};
    vecs[3]  = '{"add",       1'b0, 8'h2E, 16'h0000, 16'h0000, 9,  1'b0};
    vecs[4]  = '{"sub",       1'b0, 8'h83, 16'h0000, 16'h0000, 9,  1'b0};
    vecs[5]  = '{"div",       1'b0, 8'h57, 16'h0000, 16'h0000, 12, 1'b0};
    vecs[6]  = '{"max cap",   1'b1, 8'h40, 16'h0000, 16'hD178, 6,  1'b0};
    vecs[7]  = '{"undef",     1'b0, 8'hF0, 16'h0000, 16'h0000, 6,  1'b0};
    vecs[8]  = '{"mov",       1'b0, 8'h13, 16'h0000, 16'h0000, 6,  1'b0};
    vecs[9]  = '{"fn7",       1'b0, 8'h7C, 16'h0000, 16'h0000, 6,  1'b0};
    vecs[10] = '{"add cap",   1'b1, 8'h2E, 16'h0000, 16'h5555, 9,  1'b0};
    bb_opc  = '{8'h00, 8'h61, 8'h2E};
    bb_hold = '{6, 8, 9};

    rst = 1'b1; start = 1'b0; abort = 1'b0; prog_len = '0;
    prog_we = 1'b0; prog_addr = '0; prog_wdata = '0; drive = '0; exp_result = '0;
    #1;
    check_output("reset opcode", opcode, 8'h10);
    check_output("reset bus_oe", bus_oe, 0);
    check_output("reset busy", busy, 0);
    check_output("reset done", done, 0);
    check_output("reset pc", pc, 0);
    check_output("reset result", result, 0);
    step(); step();
    rst = 1'b0;

    $display("[TB] single-instruction table");
    for (int i = 0; i < 11; i++) apply_stimulus(vecs[i]);

    $display("[TB] back-to-back LOAD/MUL/ADD");
    write_word(6'd0, 1'b0, 8'h00, 16'h3C00);
    write_word(6'd1, 1'b0, 8'h61, 16'h0000);
    write_word(6'd2, 1'b0, 8'h2E, 16'h0000);
    pulse_start(7'd3);
    step(); step();
    for (int k = 0; k < 3; k++) begin
      check_output($sformatf("b2b pc %0d", k), pc, k);
      measure_hold(bb_opc[k], (k == 0), 16'h3C00, n, ok);
      check_output($sformatf("b2b hold %0d", k), n, bb_hold[k]);
      check_output($sformatf("b2b bus %0d", k), ok, 1);
    end
    check_output("b2b done", done, 1);
    step();

    $display("[TB] abort in 4th MUL cycle");
    write_word(6'd0, 1'b1, 8'h61, 16'h0000);
    drive = 16'hBEEF;
    pulse_start(7'd1);
    step(); step(); step(); step(); step();
    check_output("abort pre opcode", opcode, 8'h61);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_output("abort opcode", opcode, 8'h10);
    check_output("abort busy", busy, 0);
    check_output("abort bus_oe", bus_oe, 0);
    saw_done = done; saw_rv = result_valid;
    for (int c = 0; c < 12; c++) begin
      step();
      saw_done |= done; saw_rv |= result_valid;
    end
    check_output("abort no done", saw_done, 0);
    check_output("abort no capture", saw_rv, 0);
    check_output("abort result", result, exp_result);

    $display("[TB] abort coinciding with last cycle");
    write_word(6'd0, 1'b1, 8'h40, 16'h0000);
    drive = 16'h7777;
    pulse_start(7'd1);
    step(); step(); step(); step(); step(); step(); step();
    check_output("abort last opcode", opcode, 8'h40);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_output("abort last done", done, 0);
    check_output("abort last result_valid", result_valid, 0);
    check_output("abort last result", result, exp_result);

    $display("[TB] zero-length program");
    pulse_start(7'd0);
    check_output("len0 done", done, 1);
    check_output("len0 busy", busy, 0);
    step();
    check_output("len0 done end", done, 0);
    check_output("len0 busy end", busy, 0);

    $display("[TB] program writes while busy");
    write_word(6'd0, 1'b0, 8'h61, 16'h0000);
    write_word(6'd1, 1'b0, 8'h2E, 16'h0000);
    prog_len = 7'd2; start = 1'b1;
    prog_we = 1'b1; prog_addr = 6'd0; prog_wdata = {1'b0, 8'hF0, 16'h0000};
    step();
    start = 1'b0; prog_addr = 6'd1; prog_wdata = {1'b0, 8'h57, 16'h0000};
    step();
    prog_addr = 6'd0;
    step();
    prog_we = 1'b0;
    measure_hold(8'h61, 1'b0, 16'h0000, n, ok);
    check_output("wbusy hold 0", n, 8);
    measure_hold(8'h2E, 1'b0, 16'h0000, n, ok);
    check_output("wbusy hold 1", n, 9);
    check_output("wbusy done", done, 1);
    step();

    $display("[TB] full-depth program");
    for (int k = 0; k < 64; k++) write_word(6'(k), 1'b0, 8'h30 | 8'(k % 16), 16'h0000);
    pulse_start(7'd64);
    step(); step();
    for (int k = 0; k < 64; k++) begin
      check_output($sformatf("len64 pc %0d", k), pc, k);
      measure_hold(8'h30 | 8'(k % 16), 1'b0, 16'h0000, n, ok);
      check_output($sformatf("len64 hold %0d", k), n, 6);
    end
    check_output("len64 done", done, 1);
    step();

    $display("[TB] over-long program length is clamped");
    pulse_start(7'd100);
    step(); step();
    n = 0;
    while (!done && n < 500) begin
      step();
      n++;
    end
    check_output("clamp cycles to done", n, 384);
    step();
    check_output("clamp busy end", busy, 0);

    $display("[TB] reset mid-run");
    write_word(6'd0, 1'b0, 8'h00, 16'hABCD);
    pulse_start(7'd1);
    step(); step();
    check_output("rst pre bus_oe", bus_oe, 1);
    #2 rst = 1'b1;
    #1;
    exp_result = '0;
    check_output("rst opcode", opcode, 8'h10);
    check_output("rst bus_oe", bus_oe, 0);
    check_output("rst busy", busy, 0);
    check_output("rst done", done, 0);
    check_output("rst bus_out", bus_out, 0);
    check_output("rst result", result, exp_result);
    step(); step(); step();
    rst = 1'b0;
    pulse_start(7'd1);
    step(); step();
    check_output("rst rerun pc", pc, 0);
    check_output("rst rerun opcode", opcode, 8'h00);
    check_output("rst rerun bus_out", bus_out, 16'hABCD);
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    check_output("rst rerun finishes", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
